// File: rtl/count_display_driver.sv
// Binary count -> BCD (sequential double-dabble) -> time-multiplexed,
// active-low, common-anode 7-segment display of DIGITS digits.
module count_display_driver #(
  parameter int MSB         = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [MSB-1:0]    count,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              bcd_valid
);

  localparam int SW = 4*DIGITS + 4;
  localparam int BW = $clog2(MSB + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state, state_n;
  logic [MSB-1:0]      sr, sr_n, last, last_n;
  logic [SW-1:0]       scr, scr_n, adj;
  logic [BW-1:0]       bcnt, bcnt_n;
  logic [4*DIGITS-1:0] disp, disp_n;
  logic                ovf, ovf_n, valid_n;
  logic [RW-1:0]       rcnt;
  logic [IW-1:0]       dig;
  logic [3:0]          nib;
  logic                lz;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Converter: IDLE samples, SHIFT runs MSB add-3/shift steps, LATCH publishes.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    last_n  = last;
    scr_n   = scr;
    bcnt_n  = bcnt;
    disp_n  = disp;
    ovf_n   = ovf;
    valid_n = bcd_valid;
    adj     = scr;
    for (int k = 0; k <= DIGITS; k++)
      if (scr[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
    case (state)
      IDLE: if (count != last || !bcd_valid) begin
        sr_n    = count;
        last_n  = count;
        scr_n   = '0;
        bcnt_n  = BW'(MSB);
        state_n = SHIFT;
      end
      SHIFT: begin
        {scr_n, sr_n} = {adj, sr} << 1;
        bcnt_n = bcnt - BW'(1);
        if (bcnt == BW'(1)) state_n = LATCH;
      end
      LATCH: begin
        disp_n  = scr[4*DIGITS-1:0];
        ovf_n   = (scr >> (4*DIGITS)) != '0;
        valid_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= IDLE;
      sr        <= '0;
      last      <= '0;
      scr       <= '0;
      bcnt      <= '0;
      disp      <= '0;
      ovf       <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      last      <= last_n;
      scr       <= scr_n;
      bcnt      <= bcnt_n;
      disp      <= disp_n;
      ovf       <= ovf_n;
      bcd_valid <= valid_n;
    end
  end

  // Scan runs free of the converter.
  always_ff @(posedge clk) begin
    if (arst) begin
      rcnt <= '0;
      dig  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      dig  <= (dig == IW'(DIGITS - 1)) ? '0 : dig + IW'(1);
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  // A digit above 0 is a leading zero when it and every higher digit are zero.
  always_comb begin
    nib   = disp[4*dig +: 4];
    lz    = (BLANK_LZ != 0) && (dig != '0) && ((disp >> (4*dig)) == '0);
    an_n  = ~(DIGITS'(1) << dig);
    seg_n = seg7(nib);
    if (!bcd_valid) begin
      an_n  = '1;
      seg_n = 7'h7F;
    end else if (ovf) begin
      seg_n = 7'h3F;
    end else if (lz) begin
      seg_n = 7'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      seg <= 7'h7F;
      an  <= '1;
    end else begin
      seg <= seg_n;
      an  <= an_n;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: two 2-digit instances (leading
// zero blanking on/off) and one 1-digit instance for overflow and timing.
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [3:0] count = '0, count1 = '0;
  logic [6:0] seg, seg_nz, seg1;
  logic [1:0] an, an_nz;
  logic [0:0] an1;
  logic       v, v_nz, v1;

  int checks = 0, errors = 0;
  logic [13:0] sb[$];

  count_display_driver #(.MSB(4), .DIGITS(2), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .arst(arst), .count(count), .seg(seg), .an(an), .bcd_valid(v));
  count_display_driver #(.MSB(4), .DIGITS(2), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_nz (
    .clk(clk), .arst(arst), .count(count), .seg(seg_nz), .an(an_nz), .bcd_valid(v_nz));
  count_display_driver #(.MSB(4), .DIGITS(1), .REFRESH_DIV(4), .BLANK_LZ(1)) dut1 (
    .clk(clk), .arst(arst), .count(count1), .seg(seg1), .an(an1), .bcd_valid(v1));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scan one full frame of a 2-digit instance and return what each digit showed.
  task automatic capture(input int which, output logic [6:0] s1, output logic [6:0] s0,
                         output bit ok);
    bit g0 = 0, g1 = 0;
    logic [1:0] a;
    logic [6:0] s;
    s1 = 'x;
    s0 = 'x;
    for (int i = 0; i < 40 && !(g0 && g1); i++) begin
      tick();
      a = (which == 0) ? an : an_nz;
      s = (which == 0) ? seg : seg_nz;
      if (a == 2'b10) begin s0 = s; g0 = 1; end
      else if (a == 2'b01) begin s1 = s; g1 = 1; end
    end
    ok = g0 && g1;
  endtask

  task automatic test_reset;
    logic [6:0] s1, s0;
    logic [13:0] exp;
    bit ok;
    arst = 1'b1; count = 4'd7; count1 = 4'd12;
    repeat (3) tick();
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg); end
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL reset_an got %b want 11", an); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", v); end
    arst = 1'b0;
    sb.push_back({7'h7F, 7'h78});
    repeat (5) tick();
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL valid_early got %b want 0", v); end
    tick();
    checks++; if (v !== 1'b1 || v1 !== 1'b1) begin errors++; $display("FAIL valid_rise got %b/%b want 1/1", v, v1); end
    tick();
    checks++; if (seg1 !== 7'h3F || an1 !== 1'b0) begin errors++; $display("FAIL ovf12 got %h/%b want 3f/0", seg1, an1); end
    exp = sb.pop_front();
    capture(0, s1, s0, ok);
    checks++; if (!ok || {s1, s0} !== exp) begin errors++; $display("FAIL disp7 got %h %h want %h", s1, s0, exp); end
    capture(1, s1, s0, ok);
    checks++; if (!ok || {s1, s0} !== {7'h40, 7'h78}) begin errors++; $display("FAIL disp7_nz got %h %h want 40 78", s1, s0); end
  endtask

  task automatic test_sequence;
    logic [3:0]  vals [4] = '{4'd9, 4'd0, 4'd15, 4'd14};
    logic [3:0]  vals1[4] = '{4'd9, 4'd0, 4'd8, 4'd3};
    logic [13:0] em   [4] = '{{7'h7F, 7'h10}, {7'h7F, 7'h40}, {7'h79, 7'h12}, {7'h79, 7'h19}};
    logic [13:0] enz  [4] = '{{7'h40, 7'h10}, {7'h40, 7'h40}, {7'h79, 7'h12}, {7'h79, 7'h19}};
    logic [6:0]  e1   [4] = '{7'h10, 7'h40, 7'h00, 7'h30};
    logic [6:0]  prev = 7'h3F, s1, s0;
    logic [13:0] exp;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      count = vals[i]; count1 = vals1[i];
      sb.push_back(em[i]);
      repeat (6) tick();
      checks++; if (seg1 !== prev) begin errors++; $display("FAIL lat_early[%0d] got %h want %h", i, seg1, prev); end
      tick();
      checks++; if (seg1 !== e1[i]) begin errors++; $display("FAIL lat_on[%0d] got %h want %h", i, seg1, e1[i]); end
      prev = e1[i];
      exp = sb.pop_front();
      capture(0, s1, s0, ok);
      checks++; if (!ok || {s1, s0} !== exp) begin errors++; $display("FAIL seq[%0d] got %h %h want %h", i, s1, s0, exp); end
      capture(1, s1, s0, ok);
      checks++; if (!ok || {s1, s0} !== enz[i]) begin errors++; $display("FAIL seq_nz[%0d] got %h %h want %h", i, s1, s0, enz[i]); end
    end
  endtask

  task automatic test_scan;
    logic [1:0] prev, cur;
    int n, bad = 0;
    prev = an; n = 0;
    while (an == prev && n < 20) begin tick(); n++; end
    for (int r = 0; r < 4; r++) begin
      cur = an; n = 0;
      do begin
        tick(); n++;
        if (!(an == 2'b10 || an == 2'b01)) bad++;
      end while (an == cur && n < 20);
      checks++; if (n != 4) begin errors++; $display("FAIL scan_hold[%0d] got %0d want 4", r, n); end
      checks++; if (an !== ~cur) begin errors++; $display("FAIL scan_next[%0d] got %b want %b", r, an, ~cur); end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL scan_onehot got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_overflow;
    count1 = 4'd12;
    repeat (7) tick();
    checks++; if (seg1 !== 7'h3F || an1 !== 1'b0) begin errors++; $display("FAIL ovf got %h/%b want 3f/0", seg1, an1); end
    count1 = 4'd8;
    repeat (7) tick();
    checks++; if (seg1 !== 7'h00) begin errors++; $display("FAIL ovf8 got %h want 00", seg1); end
  endtask

  task automatic test_mid_shift;
    logic [6:0] s1, s0;
    logic [13:0] exp;
    bit ok;
    int bad = 0;
    count = 4'd3; count1 = 4'd3;
    repeat (2) tick();
    count = 4'd5; count1 = 4'd5;
    sb.push_back({7'h7F, 7'h12});
    repeat (5) tick();
    checks++; if (seg1 !== 7'h30) begin errors++; $display("FAIL mid_first got %h want 30", seg1); end
    for (int i = 0; i < 5; i++) begin tick(); if (seg1 !== 7'h30) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_hold got %0d bad cycles want 0", bad); end
    tick();
    checks++; if (seg1 !== 7'h12) begin errors++; $display("FAIL mid_second got %h want 12", seg1); end
    exp = sb.pop_front();
    capture(0, s1, s0, ok);
    checks++; if (!ok || {s1, s0} !== exp) begin errors++; $display("FAIL mid_disp got %h %h want %h", s1, s0, exp); end
  endtask

  task automatic test_reset_mid;
    logic [6:0] s1, s0;
    logic [13:0] exp;
    bit ok;
    count = 4'd13; count1 = 4'd13;
    repeat (3) tick();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    checks++; if (seg !== 7'h7F || an !== 2'b11 || v !== 1'b0) begin errors++; $display("FAIL rmid got %h/%b/%b want 7f/11/0", seg, an, v); end
    checks++; if (seg1 !== 7'h7F || an1 !== 1'b1 || v1 !== 1'b0) begin errors++; $display("FAIL rmid1 got %h/%b/%b want 7f/1/0", seg1, an1, v1); end
    sb.push_back({7'h79, 7'h30});
    repeat (5) tick();
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL rmid_early got %b want 0", v); end
    tick();
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL rmid_valid got %b want 1", v); end
    tick();
    checks++; if (seg1 !== 7'h3F) begin errors++; $display("FAIL rmid_ovf got %h want 3f", seg1); end
    exp = sb.pop_front();
    capture(0, s1, s0, ok);
    checks++; if (!ok || {s1, s0} !== exp) begin errors++; $display("FAIL rmid_disp got %h %h want %h", s1, s0, exp); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_scan();
    test_overflow();
    test_mid_shift();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
